avg_seq_decode: RTL
===================

Name: avg_seq_decode

Overview:
- Sequential successor to the combinational AVG decoder: fetches 16-bit words from vector memory, assembles 1- or 2-word AVG instructions, decodes them, and executes flow control (JMP/JSR/RTS/HALT) internally using a PC and a parametrised return stack.
- Draw commands (VCTR, SVEC, CNTR, STAT, SCAL) go to the vector generator over a valid/ready handshake.
- Sits between the vector-RAM/ROM read port and the vector generator; started by the CPU "go" strobe.

Parameters:
- ADDR_W, 14, PC width in bytes (word address = PC[ADDR_W-1:1])
- STACK_DEPTH, 4, return-stack entries (>=1)
- COORD_W, 13, width of sign-extended cmd_dx/cmd_dy
- SVEC_SHIFT, 0, left shift applied to SVEC deltas after sign extension
- Z_W, 4, intensity width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- go  in  1  one-cycle start pulse; ignored unless idle
- start_addr  in  ADDR_W  byte address loaded into PC on go (bit 0 ignored)
- mem_rd  out  1  read strobe
- mem_addr  out  ADDR_W-1  word address
- mem_rdata  in  16  read data, valid exactly 1 cycle after mem_rd
- cmd_valid  out  1  decoded draw command valid
- cmd_ready  in  1  vector generator accepts
- cmd_kind  out  3  pkg enum: VEC, CNTR, STAT, SCAL
- cmd_dx, cmd_dy  out  COORD_W  signed deltas
- cmd_blank, cmd_use_z  out  1  vector beam flags
- cmd_z  out  Z_W  intensity (vector or STAT)
- cmd_color  out  3  STAT colour
- cmd_lin  out  8  SCAL linear scale
- cmd_bin  out  3  SCAL binary scale
- busy  out  1  high from go until HALT/error
- halted  out  1  high in idle after a HALT; cleared by go
- err  out  1  sticky stack overflow/underflow; cleared by go

Behaviour:
- Reset: all outputs 0, except cmd_color=3'b010. State IDLE, PC=0, stack pointer=0. A reset mid-operation abandons the in-flight read and command.
- FSM:
  - IDLE: on go, PC<=start_addr&~1, clear halted/err, ->RD0.
  - RD0: mem_rd=1, addr=PC>>1, ->CAP0.
  - CAP0: latch hi word; PC+=2; opcode VCTR ->RD1, else ->EXEC.
  - RD1/CAP1: same for lo word; PC+=2.
  - EXEC: one cycle. Draw ops load the cmd registers ->ISSUE. Flow ops update PC/stack ->RD0.
  - ISSUE: cmd_valid=1, fields stable until cmd_ready; on the accept cycle ->RD0.
- Timing: go-to-cmd_valid is 4 cycles for 1-word ops and 6 cycles for VCTR. Back-to-back SVECs with cmd_ready tied high take 4 cycles each.
- Decoding (inst={hi,lo}, 32 bits; 1-word ops use hi only):
  - VCTR 000: dy=sext(inst[28:16]), dx=sext(inst[12:0]), zfield=inst[15:13].
  - SVEC 010: dy=sext(inst[28:24])<<SVEC_SHIFT, dx=sext(inst[20:16])<<SVEC_SHIFT, zfield=inst[23:21].
  - Vector zfield: 0 -> blank=1; 1 -> use_z=1; else z={zfield,0}.
  - STORE 011: inst[28]=0 is STAT (color=inst[26:24], z=inst[19:16]); inst[28]=1 is SCAL (lin=inst[23:16], bin=inst[26:24]).
  - CNTR 100: kind CNTR, deltas 0.
  - HALT 001: ->IDLE, halted=1.
  - JMP 111: PC<=inst[28:16]<<1, truncated to ADDR_W.
  - JSR 101: push the incremented PC, then jump.
  - RTS 110: pop into PC.
- Boundaries:
  - JSR with stack full, or RTS with stack empty: no PC/stack change, err=1, halted=1, ->IDLE.
  - PC increment and jump target wrap modulo 2^ADDR_W.
  - go while busy is ignored.
  - cmd_ready while cmd_valid=0 is ignored.
- busy = state != IDLE.

Decomposition:
- avg_pkg: opcode localparams OP_VCTR..OP_JMP, cmd_kind_t enum, state enum, zfield decode function.
- One sub-module: avg_ret_stack (push/pop, full/empty, depth STACK_DEPTH, async active-low reset).

Test Plan:
- SVEC: mem[0]=0x43FE, mem[1]=0x2000 (HALT), go at 0 -> cmd_valid at cycle 4 with kind=VEC, dy=3, dx=-2, z=14, blank=0; then halted=1, busy=0.
- VCTR: mem[0]=0x0010, mem[1]=0xE005 -> dy=16, dx=5, z=14 at cycle 6. With zfield=0 (lo=0x0005) -> blank=1.
- Backpressure: hold cmd_ready=0 for 10 cycles -> cmd fields stable and no mem_rd issued; the next fetch starts the cycle after accept.
- JSR/RTS: 0x0:0xA080 (JSR 0x100), 0x2:0x2000 (HALT), 0x100:0x6912 (STAT color 1, z 2), 0x102:0xC000 (RTS) -> STAT issued, return to 0x2, halted=1, err=0.
- Overflow with STACK_DEPTH=2: three nested JSRs -> err=1, halted=1 at the third. Underflow: a lone RTS -> err=1.
- Reset: assert rst_n=0 during ISSUE -> cmd_valid=0 immediately, busy=0; after release, go restarts cleanly.

Source files
------------

// File: rtl/avg_pkg.sv
// Shared opcodes, command kinds, FSM states and the vector intensity decode
// for the sequential AVG decoder.
package avg_pkg;

    localparam logic [2:0] OP_VCTR  = 3'd0;
    localparam logic [2:0] OP_HALT  = 3'd1;
    localparam logic [2:0] OP_SVEC  = 3'd2;
    localparam logic [2:0] OP_STORE = 3'd3;
    localparam logic [2:0] OP_CNTR  = 3'd4;
    localparam logic [2:0] OP_JSR   = 3'd5;
    localparam logic [2:0] OP_RTS   = 3'd6;
    localparam logic [2:0] OP_JMP   = 3'd7;

    typedef enum logic [2:0] {
        KIND_VEC  = 3'd0,
        KIND_CNTR = 3'd1,
        KIND_STAT = 3'd2,
        KIND_SCAL = 3'd3
    } cmd_kind_t;

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_CAP0, S_RD1, S_CAP1, S_EXEC, S_ISSUE
    } state_t;

    typedef struct packed {
        logic       blank;
        logic       use_z;
        logic [3:0] z;
    } zdec_t;

    // zfield 0 blanks the beam, 1 defers to the current STAT intensity.
    function automatic zdec_t zdecode(input logic [2:0] zf);
        zdec_t r;
        r.blank = (zf == 3'd0);
        r.use_z = (zf == 3'd1);
        r.z     = (r.blank || r.use_z) ? 4'd0 : {zf, 1'b0};
        return r;
    endfunction

endpackage

// File: rtl/avg_ret_stack.sv
// Subroutine return-address stack: push/pop with full/empty flags.
module avg_ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int IX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0] sp;
    logic [W-1:0]    mem [DEPTH];
    logic [IX_W-1:0] wr_ix, rd_ix;

    assign wr_ix = IX_W'(sp);
    assign rd_ix = IX_W'(sp - SP_W'(1));
    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);
    assign top   = empty ? '0 : mem[rd_ix];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sp <= '0;
        else if (push && !full)
            sp <= sp + SP_W'(1);
        else if (pop && !empty)
            sp <= sp - SP_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ix] <= din;
    end

endmodule

// File: rtl/avg_seq_decode.sv
// Sequential AVG decoder: fetches 1/2-word instructions, runs flow control
// locally and hands draw commands to the vector generator via valid/ready.
module avg_seq_decode
    import avg_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int STACK_DEPTH = 4,
    parameter int COORD_W     = 13,
    parameter int SVEC_SHIFT  = 0,
    parameter int Z_W         = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [ADDR_W-1:0]  start_addr,
    output logic               mem_rd,
    output logic [ADDR_W-2:0]  mem_addr,
    input  logic [15:0]        mem_rdata,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [2:0]         cmd_kind,
    output logic [COORD_W-1:0] cmd_dx,
    output logic [COORD_W-1:0] cmd_dy,
    output logic               cmd_blank,
    output logic               cmd_use_z,
    output logic [Z_W-1:0]     cmd_z,
    output logic [2:0]         cmd_color,
    output logic [7:0]         cmd_lin,
    output logic [2:0]         cmd_bin,
    output logic               busy,
    output logic               halted,
    output logic               err
);
    state_t             state;
    cmd_kind_t          kind_q;
    logic [ADDR_W-1:0]  pc, pc_inc, jmp_target, ret_top;
    logic [15:0]        hi, lo;
    logic [2:0]         op;
    logic               stk_push, stk_pop, stk_full, stk_empty;
    zdec_t              zd;
    logic [COORD_W-1:0] vec_dx, vec_dy;

    assign op         = hi[15:13];
    assign pc_inc     = pc + ADDR_W'(2);
    assign jmp_target = ADDR_W'({hi[12:0], 1'b0});

    assign mem_rd   = (state == S_RD0) || (state == S_RD1);
    assign mem_addr = pc[ADDR_W-1:1];
    assign busy     = (state != S_IDLE);
    assign cmd_kind = kind_q;

    // VCTR takes its deltas/zfield across both words, SVEC packs all in hi.
    always_comb begin
        if (op == OP_VCTR) begin
            zd     = zdecode(lo[15:13]);
            vec_dy = COORD_W'($signed(hi[12:0]));
            vec_dx = COORD_W'($signed(lo[12:0]));
        end else begin
            zd     = zdecode(hi[7:5]);
            vec_dy = COORD_W'($signed(hi[12:8])) <<< SVEC_SHIFT;
            vec_dx = COORD_W'($signed(hi[4:0])) <<< SVEC_SHIFT;
        end
    end

    // pc already points past the JSR when EXEC pushes it.
    assign stk_push = (state == S_EXEC) && (op == OP_JSR) && !stk_full;
    assign stk_pop  = (state == S_EXEC) && (op == OP_RTS) && !stk_empty;

    avg_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc),
        .top   (ret_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            hi        <= '0;
            lo        <= '0;
            kind_q    <= KIND_VEC;
            cmd_valid <= 1'b0;
            cmd_dx    <= '0;
            cmd_dy    <= '0;
            cmd_blank <= 1'b0;
            cmd_use_z <= 1'b0;
            cmd_z     <= '0;
            cmd_color <= 3'b010;
            cmd_lin   <= '0;
            cmd_bin   <= '0;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (go) begin
                    pc     <= start_addr & ~ADDR_W'(1);
                    halted <= 1'b0;
                    err    <= 1'b0;
                    state  <= S_RD0;
                end
                S_RD0: state <= S_CAP0;
                S_CAP0: begin
                    hi    <= mem_rdata;
                    pc    <= pc_inc;
                    state <= (mem_rdata[15:13] == OP_VCTR) ? S_RD1 : S_EXEC;
                end
                S_RD1: state <= S_CAP1;
                S_CAP1: begin
                    lo    <= mem_rdata;
                    pc    <= pc_inc;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (op)
                        OP_VCTR, OP_SVEC: begin
                            kind_q    <= KIND_VEC;
                            cmd_dx    <= vec_dx;
                            cmd_dy    <= vec_dy;
                            cmd_blank <= zd.blank;
                            cmd_use_z <= zd.use_z;
                            cmd_z     <= Z_W'(zd.z);
                            cmd_valid <= 1'b1;
                            state     <= S_ISSUE;
                        end
                        OP_STORE: begin
                            if (hi[12]) begin
                                kind_q  <= KIND_SCAL;
                                cmd_lin <= hi[7:0];
                                cmd_bin <= hi[10:8];
                            end else begin
                                kind_q    <= KIND_STAT;
                                cmd_color <= hi[10:8];
                                cmd_z     <= Z_W'(hi[3:0]);
                            end
                            cmd_valid <= 1'b1;
                            state     <= S_ISSUE;
                        end
                        OP_CNTR: begin
                            kind_q    <= KIND_CNTR;
                            cmd_dx    <= '0;
                            cmd_dy    <= '0;
                            cmd_valid <= 1'b1;
                            state     <= S_ISSUE;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_IDLE;
                        end
                        OP_JMP: begin
                            pc    <= jmp_target;
                            state <= S_RD0;
                        end
                        OP_JSR: begin
                            if (stk_full) begin
                                err    <= 1'b1;
                                halted <= 1'b1;
                                state  <= S_IDLE;
                            end else begin
                                pc    <= jmp_target;
                                state <= S_RD0;
                            end
                        end
                        OP_RTS: begin
                            if (stk_empty) begin
                                err    <= 1'b1;
                                halted <= 1'b1;
                                state  <= S_IDLE;
                            end else begin
                                pc    <= ret_top;
                                state <= S_RD0;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
                S_ISSUE: if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    state     <= S_RD0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
